// File: rtl/ahb_to_isram.sv
// AHB-Lite zero-wait-state slave in front of a one-cycle-latency block RAM.
// Writes colliding with a read address phase are parked in a one-entry buffer.
module ahb_to_isram #(
  parameter int AW = 16
) (
  input  logic          HCLK,
  input  logic          HRESETn,
  input  logic          HSEL,
  input  logic          HREADY,
  input  logic [1:0]    HTRANS,
  input  logic [2:0]    HSIZE,
  input  logic          HWRITE,
  input  logic [AW+1:0] HADDR,
  input  logic [31:0]   HWDATA,
  output logic          HREADYOUT,
  output logic          HRESP,
  output logic [31:0]   HRDATA,
  output logic [AW-1:0] SRAMADDR,
  output logic [31:0]   SRAMWDATA,
  output logic [3:0]    SRAMWEN,
  output logic          SRAMCS,
  input  logic [31:0]   SRAMRDATA
);

  logic          acc, rd_ap, wr_ap;
  logic [3:0]    mask;

  logic          wr_dp_q;
  logic [AW-1:0] wr_addr_q;
  logic [3:0]    wr_mask_q;
  logic          rd_dp_q;
  logic [AW-1:0] rd_addr_q;
  logic          buf_pend_q;
  logic [AW-1:0] buf_addr_q;
  logic [3:0]    buf_mask_q;
  logic [31:0]   buf_data_q;
  logic [AW-1:0] sram_addr_q, sram_addr_d;
  logic [31:0]   sram_wdata_q, sram_wdata_d;

  logic          sram_cs_d;
  logic [3:0]    sram_wen_d;
  logic          drain;
  logic          park;
  logic          fwd;
  logic [31:0]   merged;
  logic          unused_ok;

  assign unused_ok = HTRANS[0];

  assign acc   = HSEL & HREADY & HTRANS[1];
  assign rd_ap = acc & ~HWRITE;
  assign wr_ap = acc & HWRITE;
  assign park  = wr_dp_q & rd_ap;

  always_comb begin
    mask = 4'b1111;
    unique case (1'b1)
      (HSIZE == 3'd0): mask = 4'b0001 << HADDR[1:0];
      (HSIZE == 3'd1): mask = HADDR[1] ? 4'b1100 : 4'b0011;
      default:         mask = 4'b1111;
    endcase
  end

  // Read address phase owns the port; pending writes wait their turn.
  always_comb begin
    sram_cs_d    = 1'b0;
    sram_wen_d   = 4'b0000;
    sram_addr_d  = sram_addr_q;
    sram_wdata_d = sram_wdata_q;
    drain        = 1'b0;
    if (HRESETn) begin
      if (rd_ap) begin
        sram_cs_d   = 1'b1;
        sram_addr_d = HADDR[AW+1:2];
      end else if (wr_dp_q) begin
        sram_cs_d    = 1'b1;
        sram_wen_d   = wr_mask_q;
        sram_addr_d  = wr_addr_q;
        sram_wdata_d = HWDATA;
      end else if (buf_pend_q) begin
        sram_cs_d    = 1'b1;
        sram_wen_d   = buf_mask_q;
        sram_addr_d  = buf_addr_q;
        sram_wdata_d = buf_data_q;
        drain        = 1'b1;
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      wr_dp_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_mask_q    <= '0;
      rd_dp_q      <= 1'b0;
      rd_addr_q    <= '0;
      buf_pend_q   <= 1'b0;
      buf_addr_q   <= '0;
      buf_mask_q   <= '0;
      buf_data_q   <= '0;
      sram_addr_q  <= '0;
      sram_wdata_q <= '0;
    end else begin
      wr_dp_q <= wr_ap;
      if (wr_ap) begin
        wr_addr_q <= HADDR[AW+1:2];
        wr_mask_q <= mask;
      end
      rd_dp_q <= rd_ap;
      if (rd_ap) begin
        rd_addr_q <= HADDR[AW+1:2];
      end
      if (park) begin
        buf_pend_q <= 1'b1;
        buf_addr_q <= wr_addr_q;
        buf_mask_q <= wr_mask_q;
        buf_data_q <= HWDATA;
      end else if (drain) begin
        buf_pend_q <= 1'b0;
      end
      sram_addr_q  <= sram_addr_d;
      sram_wdata_q <= sram_wdata_d;
    end
  end

  // Buffer stays valid through its drain cycle, so forwarding still holds there.
  assign fwd = buf_pend_q & (buf_addr_q == rd_addr_q);

  always_comb begin
    merged = SRAMRDATA;
    for (int i = 0; i < 4; i++) begin
      if (fwd & buf_mask_q[i]) begin
        merged[8*i +: 8] = buf_data_q[8*i +: 8];
      end
    end
  end

  assign HRDATA    = rd_dp_q ? merged : 32'h0;
  assign HREADYOUT = 1'b1;
  assign HRESP     = 1'b0;
  assign SRAMCS    = sram_cs_d;
  assign SRAMWEN   = sram_wen_d;
  assign SRAMADDR  = sram_addr_d;
  assign SRAMWDATA = sram_wdata_d;

endmodule

// File: tb/tb_ahb_to_isram.sv
// Directed bench for ahb_to_isram with a behavioural one-cycle block RAM.
// Inputs change 1 ns after the rising edge; outputs are sampled at the falling edge.
module tb_ahb_to_isram;

  localparam int AW = 16;

  logic          HCLK = 1'b0;
  logic          HRESETn = 1'b0;
  logic          HSEL = 1'b0;
  logic          HREADY = 1'b1;
  logic [1:0]    HTRANS = 2'b00;
  logic [2:0]    HSIZE = 3'd2;
  logic          HWRITE = 1'b0;
  logic [AW+1:0] HADDR = '0;
  logic [31:0]   HWDATA = '0;
  logic          HREADYOUT;
  logic          HRESP;
  logic [31:0]   HRDATA;
  logic [AW-1:0] SRAMADDR;
  logic [31:0]   SRAMWDATA;
  logic [3:0]    SRAMWEN;
  logic          SRAMCS;
  logic [31:0]   SRAMRDATA = '0;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [0:(1<<AW)-1];

  ahb_to_isram #(.AW(AW)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HREADY(HREADY),
    .HTRANS(HTRANS), .HSIZE(HSIZE), .HWRITE(HWRITE), .HADDR(HADDR),
    .HWDATA(HWDATA), .HREADYOUT(HREADYOUT), .HRESP(HRESP),
    .HRDATA(HRDATA), .SRAMADDR(SRAMADDR), .SRAMWDATA(SRAMWDATA),
    .SRAMWEN(SRAMWEN), .SRAMCS(SRAMCS), .SRAMRDATA(SRAMRDATA)
  );

  always #5 HCLK = ~HCLK;

  initial begin
    for (int i = 0; i < (1<<AW); i++) mem[i] = 32'h0;
  end

  always @(posedge HCLK) begin
    if (SRAMCS) begin
      if (SRAMWEN == 4'b0000) begin
        SRAMRDATA <= mem[SRAMADDR];
      end else begin
        for (int i = 0; i < 4; i++)
          if (SRAMWEN[i]) mem[SRAMADDR][8*i +: 8] <= SRAMWDATA[8*i +: 8];
      end
    end
  end

  always @(negedge HCLK) begin
    if (HRESETn) begin
      assert (!(dut.wr_dp_q && !dut.rd_ap && dut.buf_pend_q)) else begin
        errors++;
        $error("FAIL invariant wr_dp=%0b buf_pend=%0b", dut.wr_dp_q, dut.buf_pend_q);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic rn, input logic tr, input logic wr,
                      input logic [2:0] sz, input logic [AW+1:0] a,
                      input logic [31:0] wd);
    @(posedge HCLK);
    #1;
    HRESETn = rn;
    HSEL    = tr;
    HTRANS  = tr ? 2'b10 : 2'b00;
    HWRITE  = wr;
    HSIZE   = sz;
    HADDR   = a;
    HWDATA  = wd;
    #4;
  endtask

  task automatic idle(input logic [31:0] wd);
    step(1'b1, 1'b0, 1'b0, 3'd2, '0, wd);
  endtask

  task automatic wr(input logic [2:0] sz, input logic [AW+1:0] a, input logic [31:0] wd);
    step(1'b1, 1'b1, 1'b1, sz, a, wd);
  endtask

  task automatic rd(input logic [AW+1:0] a, input logic [31:0] wd);
    step(1'b1, 1'b1, 1'b0, 3'd2, a, wd);
  endtask

  initial begin
    step(1'b0, 1'b0, 1'b0, 3'd2, '0, '0);
    chk("rst_cs", {31'b0, SRAMCS}, 32'h0);
    chk("rst_wen", {28'b0, SRAMWEN}, 32'h0);
    step(1'b0, 1'b0, 1'b0, 3'd2, '0, '0);
    idle(32'h0);
    chk("rst_hrdata", HRDATA, 32'h0);
    chk("rst_hreadyout", {31'b0, HREADYOUT}, 32'h1);
    chk("rst_hresp", {31'b0, HRESP}, 32'h0);
    chk("rst_buf", {31'b0, dut.buf_pend_q}, 32'h0);

    // word write then read
    wr(3'd2, 18'h10, 32'h0);
    idle(32'hDEADBEEF);
    chk("w1_cs", {31'b0, SRAMCS}, 32'h1);
    chk("w1_wen", {28'b0, SRAMWEN}, 32'hF);
    chk("w1_addr", {16'b0, SRAMADDR}, 32'h4);
    chk("w1_wdata", SRAMWDATA, 32'hDEADBEEF);
    idle(32'h0);
    rd(18'h10, 32'h0);
    chk("r1_cs", {31'b0, SRAMCS}, 32'h1);
    chk("r1_wen", {28'b0, SRAMWEN}, 32'h0);
    idle(32'h0);
    chk("r1_data", HRDATA, 32'hDEADBEEF);

    // byte writes
    wr(3'd0, 18'h20, 32'h0);
    wr(3'd0, 18'h21, 32'h00000011);
    chk("b0_wen", {28'b0, SRAMWEN}, 32'h1);
    wr(3'd0, 18'h22, 32'h00002200);
    chk("b1_wen", {28'b0, SRAMWEN}, 32'h2);
    wr(3'd0, 18'h23, 32'h00330000);
    chk("b2_wen", {28'b0, SRAMWEN}, 32'h4);
    idle(32'h44000000);
    chk("b3_wen", {28'b0, SRAMWEN}, 32'h8);
    chk("b3_addr", {16'b0, SRAMADDR}, 32'h8);
    rd(18'h20, 32'h0);
    idle(32'h0);
    chk("b_data", HRDATA, 32'h44332211);

    // write immediately followed by read of same address
    wr(3'd2, 18'h40, 32'h0);
    rd(18'h40, 32'hCAFEF00D);
    chk("p_rd_wen", {28'b0, SRAMWEN}, 32'h0);
    idle(32'h0);
    chk("p_buf", {31'b0, dut.buf_pend_q}, 32'h1);
    chk("p_fwd", HRDATA, 32'hCAFEF00D);
    chk("p_drain_wen", {28'b0, SRAMWEN}, 32'hF);
    chk("p_drain_addr", {16'b0, SRAMADDR}, 32'h10);
    chk("p_drain_data", SRAMWDATA, 32'hCAFEF00D);
    idle(32'h0);
    chk("p_buf_clr", {31'b0, dut.buf_pend_q}, 32'h0);
    chk("p_mem", mem[16'h10], 32'hCAFEF00D);

    // partial forward of a halfword
    wr(3'd2, 18'h40, 32'h0);
    idle(32'h12345678);
    wr(3'd1, 18'h42, 32'h0);
    rd(18'h40, 32'hABCD0000);
    idle(32'h0);
    chk("h_fwd", HRDATA, 32'hABCD5678);
    chk("h_drain_wen", {28'b0, SRAMWEN}, 32'hC);
    idle(32'h0);
    rd(18'h40, 32'h0);
    idle(32'h0);
    chk("h_mem", HRDATA, 32'hABCD5678);

    // streaming writes then reads
    for (int i = 0; i < 8; i++) begin
      wr(3'd2, 18'h100 + 18'(4*i), (i == 0) ? 32'h0 : 32'hA5000000 + 32'(i-1));
      chk("s_wr_ready", {31'b0, HREADYOUT}, 32'h1);
    end
    for (int i = 0; i < 8; i++) begin
      rd(18'h100 + 18'(4*i), (i == 0) ? 32'hA5000007 : 32'h0);
      chk("s_rd_ready", {31'b0, HREADYOUT}, 32'h1);
      if (i > 0) chk("s_rd_data", HRDATA, 32'hA5000000 + 32'(i-1));
    end
    idle(32'h0);
    chk("s_rd_last", HRDATA, 32'hA5000007);
    chk("s_drain_addr", {16'b0, SRAMADDR}, 32'h47);
    idle(32'h0);
    chk("s_mem_last", mem[16'h47], 32'hA5000007);

    // parked write discarded by reset
    wr(3'd2, 18'h200, 32'h0);
    idle(32'h55AA55AA);
    wr(3'd2, 18'h200, 32'h0);
    rd(18'h204, 32'h0BADF00D);
    step(1'b0, 1'b0, 1'b0, 3'd2, '0, '0);
    chk("r_buf_before", {31'b0, dut.buf_pend_q}, 32'h1);
    chk("r_cs_in_rst", {31'b0, SRAMCS}, 32'h0);
    chk("r_wen_in_rst", {28'b0, SRAMWEN}, 32'h0);
    idle(32'h0);
    chk("r_buf_after", {31'b0, dut.buf_pend_q}, 32'h0);
    chk("r_wen_after", {28'b0, SRAMWEN}, 32'h0);
    chk("r_hrdata_after", HRDATA, 32'h0);
    rd(18'h200, 32'h0);
    chk("r_wen_rd", {28'b0, SRAMWEN}, 32'h0);
    idle(32'h0);
    chk("r_old", HRDATA, 32'h55AA55AA);
    chk("r_wen_end", {28'b0, SRAMWEN}, 32'h0);
    idle(32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
